// File: rtl/vend_io.sv
// IO-space responder for the coffee machine: coin FIFO, dispense valve timer,
// change-pulse generator and panel display buffer (enabled by VEND_IO_DISPLAY_EN).
module vend_io #(
    parameter int word_sz       = 8,
    parameter int fifo_depth    = 4,
    parameter int prescale      = 16,
    parameter int chg_gap       = 3,
    parameter int def_disp_time = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [word_sz-1:0] address,
    input  logic [word_sz-1:0] data_in,
    input  logic               io_write,
    output logic [word_sz-1:0] data_out,
    input  logic               coin_valid,
    input  logic [word_sz-1:0] coin_value,
    output logic [3:0]         valve,
    output logic               change_pulse,
    input  logic [3:0]         disp_addr,
    output logic [word_sz-1:0] disp_data
);

    localparam int PW = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
    localparam int CW = $clog2(fifo_depth + 1);
    localparam int GW = (chg_gap > 1) ? $clog2(chg_gap) : 1;

    typedef logic [word_sz-1:0] word_t;

    localparam word_t ADDR_STATUS = word_t'(8'h00);
    localparam word_t ADDR_COIN   = word_t'(8'h01);
    localparam word_t ADDR_DISP   = word_t'(8'h02);
    localparam word_t ADDR_TIME   = word_t'(8'h03);
    localparam word_t ADDR_CHANGE = word_t'(8'h04);

    typedef enum logic {D_IDLE, D_RUN} disp_state_t;
    typedef enum logic [1:0] {C_IDLE, C_PULSE, C_GAP} chg_state_t;

    logic          w_wr_status, w_wr_coin, w_wr_disp, w_wr_time, w_wr_chg;
    word_t         r_fifo [fifo_depth];
    logic [PW-1:0] r_rd_ptr, r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic          w_empty, w_full, w_pop, w_push;
    word_t         r_disp_time;
    disp_state_t   r_disp_state, w_disp_state_nxt;
    logic [15:0]   r_disp_cnt, w_disp_cnt_nxt, w_disp_load;
    logic [3:0]    r_valve, w_valve_nxt;
    logic          w_disp_done, w_disp_start;
    chg_state_t    r_chg_state, w_chg_state_nxt;
    word_t         r_chg_cnt, w_chg_cnt_nxt;
    logic [GW-1:0] r_gap, w_gap_nxt;
    logic          w_chg_start;
    word_t         w_status, w_coin_head, w_rdata;

    assign w_wr_status = io_write && (address == ADDR_STATUS);
    assign w_wr_coin   = io_write && (address == ADDR_COIN);
    assign w_wr_disp   = io_write && (address == ADDR_DISP);
    assign w_wr_time   = io_write && (address == ADDR_TIME);
    assign w_wr_chg    = io_write && (address == ADDR_CHANGE);

    // A push into a full FIFO still succeeds when the head is popped in the same cycle.
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(fifo_depth));
    assign w_pop   = w_wr_coin && !w_empty;
    assign w_push  = coin_valid && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= coin_value;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= (r_wr_ptr == PW'(fifo_depth - 1)) ? '0 : r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= (r_rd_ptr == PW'(fifo_depth - 1)) ? '0 : r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (coin_valid && w_full && !w_pop) r_ovf <= 1'b1;
            else if (w_wr_status && data_in[3]) r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_disp_time <= word_t'(def_disp_time);
        else if (w_wr_time) r_disp_time <= data_in;
    end

    // The final countdown edge may also accept the next dispense, so it reloads instead of idling.
    assign w_disp_load  = 16'(r_disp_time) * 16'(prescale);
    assign w_disp_done  = (r_disp_state == D_RUN) && (r_disp_cnt == 16'd1);
    assign w_disp_start = w_wr_disp && ((r_disp_state == D_IDLE) || w_disp_done)
                          && (data_in[3:0] != 4'h0) && (r_disp_time != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_disp_state <= D_IDLE;
            r_disp_cnt   <= '0;
            r_valve      <= '0;
        end else begin
            r_disp_state <= w_disp_state_nxt;
            r_disp_cnt   <= w_disp_cnt_nxt;
            r_valve      <= w_valve_nxt;
        end
    end

    always_comb begin
        w_disp_state_nxt = r_disp_state;
        w_disp_cnt_nxt   = r_disp_cnt;
        w_valve_nxt      = r_valve;
        case (r_disp_state)
            D_IDLE: begin
                if (w_disp_start) begin
                    w_disp_state_nxt = D_RUN;
                    w_disp_cnt_nxt   = w_disp_load;
                    w_valve_nxt      = data_in[3:0];
                end
            end
            D_RUN: begin
                if (w_disp_start) begin
                    w_disp_cnt_nxt = w_disp_load;
                    w_valve_nxt    = data_in[3:0];
                end else if (w_disp_done) begin
                    w_disp_state_nxt = D_IDLE;
                    w_disp_cnt_nxt   = '0;
                    w_valve_nxt      = '0;
                end else begin
                    w_disp_cnt_nxt = r_disp_cnt - 16'd1;
                end
            end
            default: w_disp_state_nxt = D_IDLE;
        endcase
    end

    assign w_chg_start = w_wr_chg && (r_chg_state == C_IDLE) && (data_in != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_chg_state <= C_IDLE;
            r_chg_cnt   <= '0;
            r_gap       <= '0;
        end else begin
            r_chg_state <= w_chg_state_nxt;
            r_chg_cnt   <= w_chg_cnt_nxt;
            r_gap       <= w_gap_nxt;
        end
    end

    // The remaining count drops as each pulse completes; the gap counter times the low interval.
    always_comb begin
        w_chg_state_nxt = r_chg_state;
        w_chg_cnt_nxt   = r_chg_cnt;
        w_gap_nxt       = r_gap;
        case (r_chg_state)
            C_IDLE: begin
                if (w_chg_start) begin
                    w_chg_state_nxt = C_PULSE;
                    w_chg_cnt_nxt   = data_in;
                end
            end
            C_PULSE: begin
                w_chg_cnt_nxt = r_chg_cnt - word_t'(1);
                if (chg_gap == 0) begin
                    w_chg_state_nxt = (w_chg_cnt_nxt != '0) ? C_PULSE : C_IDLE;
                end else begin
                    w_chg_state_nxt = C_GAP;
                    w_gap_nxt       = GW'(chg_gap - 1);
                end
            end
            C_GAP: begin
                if (r_gap == '0) w_chg_state_nxt = (r_chg_cnt != '0) ? C_PULSE : C_IDLE;
                else             w_gap_nxt = r_gap - GW'(1);
            end
            default: w_chg_state_nxt = C_IDLE;
        endcase
    end

    assign valve        = r_valve;
    assign change_pulse = (r_chg_state == C_PULSE);
    assign w_status     = word_t'({r_ovf, (r_chg_state != C_IDLE), (r_disp_state == D_RUN), !w_empty});
    assign w_coin_head  = w_empty ? '0 : r_fifo[r_rd_ptr];

`ifdef VEND_IO_DISPLAY_EN
    word_t r_disp_mem [16];
    logic  w_disp_sel;

    assign w_disp_sel = (address[word_sz-1:4] == (word_sz - 4)'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) r_disp_mem[i] <= '0;
        end else if (io_write && w_disp_sel) begin
            r_disp_mem[address[3:0]] <= data_in;
        end
    end

    assign disp_data = r_disp_mem[disp_addr];
`else
    logic w_unused_disp_addr;
    assign w_unused_disp_addr = ^disp_addr;
    assign disp_data = '0;
`endif

    always_comb begin
        w_rdata = '0;
        case (address)
            ADDR_STATUS: w_rdata = w_status;
            ADDR_COIN:   w_rdata = w_coin_head;
            ADDR_DISP:   w_rdata = word_t'(r_valve);
            ADDR_TIME:   w_rdata = r_disp_time;
            ADDR_CHANGE: w_rdata = r_chg_cnt;
            default:     w_rdata = '0;
        endcase
`ifdef VEND_IO_DISPLAY_EN
        if (w_disp_sel) w_rdata = r_disp_mem[address[3:0]];
`endif
    end

    assign data_out = w_rdata;

endmodule
